regwb_arbiter: RTL and testbench
================================

Name: regwb_arbiter

Overview:
Shares the single register-file write port between NREQ writeback requesters, such as the ALU result path and the memory-load path. Each requester has a one-entry holding slot with a valid/ready handshake. A round-robin arbiter drains one slot per cycle onto RegWrite/WriteAddr/WriteData, which connect directly to the register file. The block also drops writes to register 0, keeps same-register writes in order, and exports a pending-write bitmap for hazard checks.

Parameters:
NREQ, 2, number of writeback requesters (2..4)
AW, 5, register address width
DW, 32, data width

Ports:
Clock  in  1  write clock, shared with the register file
Reset  in  1  asynchronous, active-low (0 = reset)
req_valid  in  NREQ  requester i presents a write
req_addr  in  NREQ*AW  destination register; slice i = [i*AW +: AW]
req_data  in  NREQ*DW  write data; slice i = [i*DW +: DW]
req_ready  out  NREQ  slot i can accept this cycle
RegWrite  out  1  register-file write enable
WriteAddr  out  AW  register-file write address
WriteData  out  DW  register-file write data
grant_id  out  2  index of the slot being drained (valid when RegWrite=1)
pending  out  2**AW  bit r=1 while any full slot targets register r

Behaviour:
- Per-slot state: EMPTY or FULL.
  - EMPTY->FULL when req_valid&req_ready and addr!=0.
  - FULL->EMPTY when the slot is granted.
  - FULL->FULL (reloaded) when the slot is granted and a new request is accepted in the same cycle.
- Accept rule: req_ready[i] = (slot i EMPTY or slot i granted this cycle) and no address conflict.
- Conflict: another FULL, non-granted slot holds the same addr, or a lower-index requester is accepted this cycle with the same addr. Consequences:
  - Same-register writes commit in acceptance order.
  - Two same-cycle requests to the same register: the lower index wins.
- Address 0: accepted (ready obeys the rules above, conflict check skipped) and discarded. The slot stays EMPTY, and no RegWrite is ever issued for address 0.
- Arbitration: round-robin among FULL slots.
  - The pointer starts at slot 0 after reset.
  - After a grant to slot g, the pointer moves to g+1 mod NREQ.
  - If no slot is FULL, the pointer holds.
- Outputs (combinational from registered slot state and the pointer):
  - RegWrite=1 iff any slot is FULL.
  - WriteAddr/WriteData/grant_id come from the granted slot; all are zero when RegWrite=0.
- Latency: a request accepted at rising edge N drives RegWrite during cycle N+1 if granted. The register file commits it at edge N+1. Minimum latency is 1 cycle; worst case is NREQ cycles when every slot is FULL.
- Throughput: one write per cycle sustained. A single requester streaming distinct addresses never stalls.
- pending: OR over FULL slots of the one-hot slot address, updated with slot state.
- Reset (Reset=0, any time, including mid-operation):
  - All slots go EMPTY immediately, the pointer goes to 0, held data is dropped.
  - RegWrite=0, WriteAddr=0, WriteData=0, grant_id=0, pending=0, req_ready=0 while Reset=0.
  - After release, req_ready follows the rules above on the first cycle.
- req_addr/req_data are sampled only on acceptance. Changes while ready=0 have no effect.

Optional Feature:
REGWB_STATS_EN. When defined, the block adds two outputs:
- stall_cnt [15:0]: saturating count of cycles with any req_valid[i]&!req_ready[i].
- write_cnt [15:0]: saturating count of RegWrite cycles.

Both counters clear on Reset and hold at 16'hFFFF. When undefined, both ports and counters are absent and the rest of the behaviour is unchanged.

Decomposition:
- Package regwb_pkg: AW, DW, NREGS=32, ZERO_ADDR=0, the slot_state_t enum {EMPTY, FULL}, and the counter width STAT_W=16.
- Sub-module rr_arbiter: NREQ request vector plus pointer in, one-hot grant plus encoded index out, pointer update. Reused for future shared-resource arbitration.

Test Plan:
1. Reset=0 with req_valid=2'b11 -> RegWrite=0, req_ready=0, pending=0; after release, req_ready=2'b11 on the first cycle.
2. Req0 writes addr 5 = 32'hDEADBEEF alone -> RegWrite=1, WriteAddr=5, WriteData=DEADBEEF, grant_id=0 in the next cycle; pending[5]=1 for exactly 1 cycle.
3. Both requesters valid every cycle with distinct addrs (0:{1,2,3}, 1:{9,10,11}) -> grants alternate 0,1,0,1,0,1; the write order seen by the register file matches.
4. Same cycle: req0 and req1 both to addr 7 (0x11 and 0x22) -> req1 is stalled; writes are 7=0x11, then 7=0x22; stall_cnt=1 with REGWB_STATS_EN.
5. Req1 writes addr 0 = 32'hFFFFFFFF -> accepted, RegWrite stays 0, pending stays 0.
6. Reset asserted with both slots FULL -> RegWrite and pending drop in the same cycle; the held data is never written after release.

Source files
------------

// File: rtl/regwb_pkg.sv
// Shared types and constants for the register-file writeback arbiter.
package regwb_pkg;

  localparam int AW     = 5;
  localparam int DW     = 32;
  localparam int NREGS  = 32;
  localparam int STAT_W = 16;

  localparam logic [AW-1:0] ZERO_ADDR = '0;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } slot_state_t;

  // Statistics counters stick at all-ones instead of wrapping.
  function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v);
    return (&v) ? v : v + {{(STAT_W-1){1'b0}}, 1'b1};
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: searches from ptr upward, wraps at N, and
// proposes the pointer that follows the winner (unchanged when nobody requests).
module rr_arbiter #(
  parameter int N = 2
) (
  input  logic [N-1:0] req,
  input  logic [1:0]   ptr,
  output logic [N-1:0] gnt,
  output logic [1:0]   gnt_idx,
  output logic         found,
  output logic [1:0]   ptr_next
);

  int slot;

  always_comb begin
    gnt      = '0;
    gnt_idx  = '0;
    found    = 1'b0;
    ptr_next = ptr;
    slot     = 0;
    for (int i = 0; i < N; i++) begin
      slot = int'(ptr) + i;
      if (slot >= N) slot = slot - N;
      for (int j = 0; j < N; j++) begin
        if (!found && (slot == j) && req[j]) begin
          found    = 1'b1;
          gnt[j]   = 1'b1;
          gnt_idx  = 2'(j);
          ptr_next = (j == N - 1) ? 2'd0 : 2'(j + 1);
        end
      end
    end
  end

endmodule

// File: rtl/regwb_arbiter.sv
// Funnels NREQ writeback requesters into the single register-file write port.
// Optional REGWB_STATS_EN adds saturating stall_cnt / write_cnt outputs.
//
// Handshake: requester i transfers on a rising edge where req_valid[i] and
// req_ready[i] are both 1; addr/data are sampled only then, and req_ready[i]
// never depends on req_valid[i] itself.
module regwb_arbiter
  import regwb_pkg::*;
#(
  parameter int NREQ = 2,
  parameter int AW   = regwb_pkg::AW,
  parameter int DW   = regwb_pkg::DW
) (
  input  logic                Clock,
  input  logic                Reset,
  input  logic [NREQ-1:0]     req_valid,
  input  logic [NREQ*AW-1:0]  req_addr,
  input  logic [NREQ*DW-1:0]  req_data,
  output logic [NREQ-1:0]     req_ready,
  output logic                RegWrite,
  output logic [AW-1:0]       WriteAddr,
  output logic [DW-1:0]       WriteData,
  output logic [1:0]          grant_id,
  output logic [2**AW-1:0]    pending
`ifdef REGWB_STATS_EN
  ,
  output logic [STAT_W-1:0]   stall_cnt,
  output logic [STAT_W-1:0]   write_cnt
`endif
);

  // Per-slot state; slot_q is the FSM state vector to probe in debug.
  slot_state_t [NREQ-1:0] slot_q;
  logic [AW-1:0]          slot_addr_q [NREQ];
  logic [DW-1:0]          slot_data_q [NREQ];
  logic [1:0]             ptr_q;
  logic [1:0]             ptr_next;

  logic [NREQ-1:0]        full;
  logic [NREQ-1:0]        gnt;
  logic [NREQ-1:0]        acc;
  logic [1:0]             gnt_idx;
  logic                   any_full;
  logic                   conflict;

  always_comb begin
    full = '0;
    for (int i = 0; i < NREQ; i++) full[i] = (slot_q[i] == FULL);
  end

  rr_arbiter #(.N(NREQ)) u_rr (
    .req      (full),
    .ptr      (ptr_q),
    .gnt      (gnt),
    .gnt_idx  (gnt_idx),
    .found    (any_full),
    .ptr_next (ptr_next)
  );

  // Acceptance is resolved in index order so a lower requester that is taken
  // this cycle blocks a higher one aimed at the same register.
  always_comb begin
    req_ready = '0;
    acc       = '0;
    conflict  = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      conflict = 1'b0;
      if (req_addr[i*AW +: AW] != AW'(ZERO_ADDR)) begin
        for (int j = 0; j < NREQ; j++) begin
          if ((j != i) && full[j] && !gnt[j] &&
              (slot_addr_q[j] == req_addr[i*AW +: AW]))
            conflict = 1'b1;
          if ((j < i) && acc[j] &&
              (req_addr[j*AW +: AW] == req_addr[i*AW +: AW]))
            conflict = 1'b1;
        end
      end
      req_ready[i] = Reset && (!full[i] || gnt[i]) && !conflict;
      acc[i]       = req_valid[i] && req_ready[i];
    end
  end

  always_comb begin
    RegWrite  = any_full;
    WriteAddr = '0;
    WriteData = '0;
    grant_id  = any_full ? gnt_idx : 2'd0;
    pending   = '0;
    for (int j = 0; j < NREQ; j++) begin
      if (gnt[j]) begin
        WriteAddr = slot_addr_q[j];
        WriteData = slot_data_q[j];
      end
      if (full[j]) pending[slot_addr_q[j]] = 1'b1;
    end
  end

  // Writes to register 0 are swallowed: accepted but never loaded into a slot.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      ptr_q <= '0;
      for (int i = 0; i < NREQ; i++) begin
        slot_q[i]      <= EMPTY;
        slot_addr_q[i] <= '0;
        slot_data_q[i] <= '0;
      end
    end else begin
      ptr_q <= ptr_next;
      for (int i = 0; i < NREQ; i++) begin
        if (acc[i] && (req_addr[i*AW +: AW] != AW'(ZERO_ADDR))) begin
          slot_q[i]      <= FULL;
          slot_addr_q[i] <= req_addr[i*AW +: AW];
          slot_data_q[i] <= req_data[i*DW +: DW];
        end else if (acc[i] || gnt[i]) begin
          slot_q[i] <= EMPTY;
        end
      end
    end
  end

`ifdef REGWB_STATS_EN
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      stall_cnt <= '0;
      write_cnt <= '0;
    end else begin
      if (|(req_valid & ~req_ready)) stall_cnt <= sat_inc(stall_cnt);
      if (RegWrite)                  write_cnt <= sat_inc(write_cnt);
    end
  end
`endif

endmodule

// File: tb/tb_regwb_arbiter.sv
// Directed bench for regwb_arbiter (NREQ=2); build with REGWB_STATS_EN to
// also check the statistics counters.
module tb_regwb_arbiter;
  import regwb_pkg::*;

  localparam int NREQ = 2;
  localparam int W    = 2 + AW + DW;

  // clock / reset
  logic Clock = 1'b0;
  logic Reset;
  always #5 Clock = ~Clock;

  logic [NREQ-1:0]    req_valid;
  logic [NREQ*AW-1:0] req_addr;
  logic [NREQ*DW-1:0] req_data;
  logic [NREQ-1:0]    req_ready;
  logic               RegWrite;
  logic [AW-1:0]      WriteAddr;
  logic [DW-1:0]      WriteData;
  logic [1:0]         grant_id;
  logic [2**AW-1:0]   pending;
`ifdef REGWB_STATS_EN
  logic [STAT_W-1:0]  stall_cnt;
  logic [STAT_W-1:0]  write_cnt;
`endif

  regwb_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW)) dut (
    .Clock     (Clock),
    .Reset     (Reset),
    .req_valid (req_valid),
    .req_addr  (req_addr),
    .req_data  (req_data),
    .req_ready (req_ready),
    .RegWrite  (RegWrite),
    .WriteAddr (WriteAddr),
    .WriteData (WriteData),
    .grant_id  (grant_id),
    .pending   (pending)
`ifdef REGWB_STATS_EN
    ,
    .stall_cnt (stall_cnt),
    .write_cnt (write_cnt)
`endif
  );

  // scoreboard
  int checks   = 0;
  int failures = 0;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] exp_w;

  logic [AW-1:0] l0 [3];
  logic [AW-1:0] l1 [3];
  int  i0, i1;
  logic a0, a1;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // driver tasks
  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic do_reset();
    Reset     = 1'b0;
    req_valid = '0;
    tick();
    Reset = 1'b1;
  endtask

  initial begin
    // 1: reset holds everything quiet even with both requesters valid
    Reset     = 1'b0;
    req_valid = 2'b11;
    req_addr  = {5'd4, 5'd3};
    req_data  = '0;
    tick();
    tick();
    chk("t1_rst_regwrite", 64'(RegWrite), 64'h0);
    chk("t1_rst_ready", 64'(req_ready), 64'h0);
    chk("t1_rst_pending", 64'(pending), 64'h0);
    chk("t1_rst_waddr", 64'(WriteAddr), 64'h0);
    req_valid = '0;
    Reset     = 1'b1;
    #1;
    chk("t1_ready_release", 64'(req_ready), 64'h3);
    tick();
    chk("t1_idle_regwrite", 64'(RegWrite), 64'h0);

    // 2: single write, one-cycle latency
    req_valid = 2'b01;
    req_addr  = {5'd0, 5'd5};
    req_data  = {32'h0, 32'hDEADBEEF};
    #1;
    chk("t2_ready0", 64'(req_ready[0]), 64'h1);
    tick();
    req_valid = '0;
    chk("t2_regwrite", 64'(RegWrite), 64'h1);
    chk("t2_waddr", 64'(WriteAddr), 64'h5);
    chk("t2_wdata", 64'(WriteData), 64'hDEADBEEF);
    chk("t2_grant", 64'(grant_id), 64'h0);
    chk("t2_pending", 64'(pending), 64'h20);
    tick();
    chk("t2_regwrite_off", 64'(RegWrite), 64'h0);
    chk("t2_pending_off", 64'(pending), 64'h0);

    // 3: both streaming distinct addresses, grants alternate from slot 0
    do_reset();
    l0 = '{5'd1, 5'd2, 5'd3};
    l1 = '{5'd9, 5'd10, 5'd11};
    exp_q.push_back({2'd0, 5'd1,  32'h101});
    exp_q.push_back({2'd1, 5'd9,  32'h109});
    exp_q.push_back({2'd0, 5'd2,  32'h102});
    exp_q.push_back({2'd1, 5'd10, 32'h10A});
    exp_q.push_back({2'd0, 5'd3,  32'h103});
    exp_q.push_back({2'd1, 5'd11, 32'h10B});
    i0 = 0;
    i1 = 0;
    for (int c = 0; c < 10; c++) begin
      req_valid = {(i1 < 3), (i0 < 3)};
      req_addr  = {(i1 < 3) ? l1[i1] : 5'd0, (i0 < 3) ? l0[i0] : 5'd0};
      req_data  = {32'h100 + 32'(req_addr[2*AW-1:AW]), 32'h100 + 32'(req_addr[AW-1:0])};
      #1;
      a0 = req_valid[0] & req_ready[0];
      a1 = req_valid[1] & req_ready[1];
      tick();
      if (a0) i0++;
      if (a1) i1++;
      if (RegWrite) begin
        if (exp_q.size() == 0) begin
          chk("t3_extra_write", 64'({grant_id, WriteAddr, WriteData}), 64'h0);
        end else begin
          exp_w = exp_q.pop_front();
          chk("t3_write", 64'({grant_id, WriteAddr, WriteData}), 64'(exp_w));
        end
      end
    end
    req_valid = '0;
    chk("t3_all_written", 64'(exp_q.size()), 64'h0);

    // 4: same-cycle collision on register 7, lower index goes first
    do_reset();
    req_valid = 2'b11;
    req_addr  = {5'd7, 5'd7};
    req_data  = {32'h22, 32'h11};
    #1;
    chk("t4_ready_collide", 64'(req_ready), 64'h1);
    tick();
    req_valid = 2'b10;
    #1;
    chk("t4_ready1_next", 64'(req_ready[1]), 64'h1);
    chk("t4_w1_regwrite", 64'(RegWrite), 64'h1);
    chk("t4_w1", 64'({grant_id, WriteAddr, WriteData}), 64'({2'd0, 5'd7, 32'h11}));
    chk("t4_w1_pending", 64'(pending), 64'h80);
    tick();
    req_valid = '0;
    chk("t4_w2", 64'({grant_id, WriteAddr, WriteData}), 64'({2'd1, 5'd7, 32'h22}));
    chk("t4_w2_pending", 64'(pending), 64'h80);
    tick();
    chk("t4_done", 64'(RegWrite), 64'h0);
`ifdef REGWB_STATS_EN
    chk("t4_stall_cnt", 64'(stall_cnt), 64'h1);
    chk("t4_write_cnt", 64'(write_cnt), 64'h2);
`endif

    // 5: register 0 is accepted and dropped
    req_valid = 2'b10;
    req_addr  = {5'd0, 5'd0};
    req_data  = {32'hFFFFFFFF, 32'h0};
    #1;
    chk("t5_ready", 64'(req_ready), 64'h3);
    tick();
    req_valid = '0;
    chk("t5_regwrite", 64'(RegWrite), 64'h0);
    chk("t5_pending", 64'(pending), 64'h0);
    tick();
    chk("t5_regwrite_later", 64'(RegWrite), 64'h0);

    // 7: one requester streaming distinct addresses never stalls
    for (int c = 0; c < 3; c++) begin
      req_valid = 2'b01;
      req_addr  = {5'd0, 5'(20 + c)};
      req_data  = {32'h0, 32'h200 + 32'(c)};
      #1;
      chk("t7_ready0", 64'(req_ready[0]), 64'h1);
      tick();
      chk("t7_write", 64'({RegWrite, WriteAddr, WriteData}), 64'({1'b1, 5'(20 + c), 32'h200 + 32'(c)}));
    end
    req_valid = '0;
    tick();
    chk("t7_drained", 64'(RegWrite), 64'h0);

    // 6: reset with both slots full discards held writes
    req_valid = 2'b11;
    req_addr  = {5'd13, 5'd12};
    req_data  = {32'hBBBB, 32'hAAAA};
    tick();
    req_valid = '0;
    chk("t6_pending_full", 64'(pending), 64'h3000);
    chk("t6_first_grant", 64'({grant_id, WriteAddr}), 64'({2'd1, 5'd13}));
    #2;
    Reset = 1'b0;
    #1;
    chk("t6_rst_regwrite", 64'(RegWrite), 64'h0);
    chk("t6_rst_pending", 64'(pending), 64'h0);
    chk("t6_rst_ready", 64'(req_ready), 64'h0);
    chk("t6_rst_outs", 64'({grant_id, WriteAddr, WriteData}), 64'h0);
    tick();
    Reset = 1'b1;
    for (int c = 0; c < 4; c++) begin
      tick();
      chk("t6_no_stale_write", 64'(RegWrite), 64'h0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
